// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in / serial-out transmitter.
// Holds the four-state frame FSM encoding and a counter sizing helper.
package piso_pkg;

    // Frame FSM state encodings, kept as named constants so other blocks
    // and checkers can refer to them without depending on the enum.
    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_START = 2'd1;
    localparam logic [1:0] ENC_DATA  = 2'd2;
    localparam logic [1:0] ENC_STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_START = ENC_START,
        ST_DATA  = ENC_DATA,
        ST_STOP  = ENC_STOP
    } piso_state_e;

    // Width of a counter that must hold values 0..n-1; never narrower
    // than one bit so a divide-by-one timer still has a legal vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/piso_tx_bit_timer.sv
// Bit-period timer for piso_tx. Counts 0..CLK_DIV-1 while enabled and
// raises tick on the last cycle of every bit period. While clear is high
// the count is held at zero and no tick is produced, so the first period
// after clear drops is a full CLK_DIV cycles long.
module bit_timer
    import piso_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned   CW   = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 32'd1);
    localparam logic [CW-1:0] ONE  = CW'(32'd1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;

    // Next count: hold at zero when cleared, wrap at the bit boundary.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clear) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (cnt_r == LAST) begin
            cnt_nxt_s = {CW{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + ONE;
        end
    end

    // Bit-cycle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign tick = (!clear) && (cnt_r == LAST);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter. Accepts a WIDTH-bit word with a
// valid/ready handshake and sends it as start(0), data LSB first, stop(1),
// each bit held for CLK_DIV clock cycles. All outputs come from flops.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   IW       = $clog2(WIDTH + 32'd1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 32'd1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);

    piso_state_e      state_r;
    piso_state_e      state_nxt_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_nxt_s;
    logic [WIDTH-1:0] shift_sh_s;
    logic [IW-1:0]    idx_r;
    logic [IW-1:0]    idx_nxt_s;
    logic             sout_r;
    logic             sout_nxt_s;
    logic             busy_r;
    logic             done_r;
    logic             done_nxt_s;
    logic             ready_r;
    logic             tick_s;
    logic             clear_s;

    // The timer only runs while a frame is in flight; in IDLE it sits at 0
    // so the start bit of the next frame gets a full bit period.
    assign clear_s    = (state_r == ST_IDLE);
    assign shift_sh_s = shift_r >> 1;

    bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Next-state and next-output logic for the frame FSM. The serial line
    // is computed one cycle ahead so sout can be a plain flop.
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        idx_nxt_s   = idx_r;
        sout_nxt_s  = sout_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sout_nxt_s = 1'b1;
                idx_nxt_s  = {IW{1'b0}};
                if (din_valid) begin
                    state_nxt_s = ST_START;
                    shift_nxt_s = din;
                    sout_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_nxt_s = ST_DATA;
                    sout_nxt_s  = shift_r[0];
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_nxt_s = shift_sh_s;
                    idx_nxt_s   = idx_r + IDX_ONE;
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_STOP;
                        sout_nxt_s  = 1'b1;
                    end else begin
                        sout_nxt_s  = shift_sh_s[0];
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = {IW{1'b0}};
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = {IW{1'b0}};
                sout_nxt_s  = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers; busy/ready mirror the next state
    // so they line up exactly with state_r after each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            shift_r <= {WIDTH{1'b0}};
            idx_r   <= {IW{1'b0}};
            sout_r  <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            shift_r <= shift_nxt_s;
            idx_r   <= idx_nxt_s;
            sout_r  <= sout_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= done_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    assign din_ready = ready_r;
    assign sout      = sout_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: one instance with CLK_DIV=4 and one with
// CLK_DIV=1, both WIDTH=8. A frame-level reference model predicts every
// output after every clock edge from "edges since acceptance" arithmetic.
module tb_piso_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din   [2];
    logic       dv    [2];
    logic       rdy   [2];
    logic       sout  [2];
    logic       busy  [2];
    logic       done  [2];

    int n_vec;
    int n_err;

    // Reference model state per instance.
    bit         m_act  [2];
    int         m_k    [2];
    logic [9:0] m_bits [2];
    bit         m_done [2];
    bit         m_acc  [2];
    bit         hold   [2];

    bit sbuf [256];

    piso_tx #(.WIDTH(8), .CLK_DIV(4)) dut0 (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(dv[0]),
        .din_ready(rdy[0]), .sout(sout[0]), .busy(busy[0]), .done(done[0])
    );

    piso_tx #(.WIDTH(8), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .din(din[1]), .din_valid(dv[1]),
        .din_ready(rdy[1]), .sout(sout[1]), .busy(busy[1]), .done(done[1])
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input int u);
        logic exp_sout;
        exp_sout = m_act[u] ? m_bits[u][m_k[u] / div_of(u)] : 1'b1;
        check_eq($sformatf("sout%0d", u),  32'(sout[u]), 32'(exp_sout));
        check_eq($sformatf("busy%0d", u),  32'(busy[u]), 32'(m_act[u]));
        check_eq($sformatf("done%0d", u),  32'(done[u]), 32'(m_done[u]));
        check_eq($sformatf("ready%0d", u), 32'(rdy[u]),  32'(!m_act[u]));
    endtask

    // One clock edge: advance the model on the inputs seen at the edge,
    // then compare both instances 1 time unit later.
    task automatic step();
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            bit ready_pre;
            ready_pre = !m_act[u];
            m_done[u] = 1'b0;
            m_acc[u]  = 1'b0;
            if (rst) begin
                m_act[u] = 1'b0;
                m_k[u]   = 0;
            end else begin
                if (m_act[u]) begin
                    m_k[u]++;
                    if (m_k[u] == 10 * div_of(u)) begin
                        m_act[u]  = 1'b0;
                        m_done[u] = 1'b1;
                    end
                end
                if (ready_pre && dv[u]) begin
                    m_act[u]  = 1'b1;
                    m_k[u]    = 0;
                    m_bits[u] = {1'b1, din[u], 1'b0};
                    m_acc[u]  = 1'b1;
                end
            end
        end
        #1;
        for (int u = 0; u < 2; u++) check_outputs(u);
    endtask

    // Assert reset between edges and check that outputs react at once.
    task automatic async_reset(input int hold_cycles);
        #2 rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
            m_act[u]  = 1'b0;
            m_done[u] = 1'b0;
            m_k[u]    = 0;
        end
        for (int u = 0; u < 2; u++) check_outputs(u);
        for (int i = 0; i < hold_cycles; i++) step();
        rst = 1'b0;
    endtask

    // Bits of a frame sampled once per bit period from sbuf.
    function automatic logic [9:0] frame_at(input int start, input int d);
        logic [9:0] f;
        for (int j = 0; j < 10; j++) f[j] = sbuf[start + d * j];
        return f;
    endfunction

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_k;
        int start2_k;
        int nacc;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int u = 0; u < 2; u++) begin
            din[u] = 8'h00; dv[u] = 1'b0;
            m_act[u] = 1'b0; m_k[u] = 0; m_done[u] = 1'b0; m_acc[u] = 1'b0;
            m_bits[u] = 10'h3FF; hold[u] = 1'b0;
        end

        // Reset state before any clock edge.
        #3;
        for (int u = 0; u < 2; u++) check_outputs(u);
        step();
        step();
        rst = 1'b0;

        // Single frame 0xA5 with a one-cycle valid.
        din[0] = 8'hA5; dv[0] = 1'b1;
        step();
        dv[0] = 1'b0; din[0] = 8'($urandom);
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 46; k++) begin
            if (k > 0) step();
            sbuf[k] = sout[0];
            busy_cnt += 32'(busy[0]);
            done_cnt += 32'(done[0]);
        end
        check_eq("a5_bits", 32'(frame_at(0, 4)), 32'(10'b1101001010));
        check_eq("a5_busy_cycles", 32'(busy_cnt), 32'd40);
        check_eq("a5_done_count", 32'(done_cnt), 32'd1);

        // Back-to-back 0x00 then 0xFF with valid held high.
        din[0] = 8'h00; dv[0] = 1'b1;
        nacc = 0; busy_cnt = 0; done_cnt = 0; done_k = -1; start2_k = -1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (m_acc[0]) begin
                nacc++;
                if (nacc == 1) din[0] = 8'hFF;
                else dv[0] = 1'b0;
            end
            busy_cnt += 32'(busy[0]);
            done_cnt += 32'(done[0]);
            if (done[0] && done_k < 0) done_k = k;
            if (done_k >= 0 && start2_k < 0 && sout[0] == 1'b0) start2_k = k;
        end
        check_eq("b2b_start_after_done", 32'(start2_k - done_k), 32'd1);
        check_eq("b2b_busy_cycles", 32'(busy_cnt), 32'd80);
        check_eq("b2b_done_count", 32'(done_cnt), 32'd2);

        // din changes to 0x3C while busy: 0xA5 goes out first, then 0x3C.
        din[0] = 8'hA5; dv[0] = 1'b1;
        step();
        sbuf[0] = sout[0];
        dv[0] = 1'b0;
        done_k = -1; start2_k = -1;
        for (int k = 1; k < 90; k++) begin
            step();
            sbuf[k] = sout[0];
            if (k == 3) begin din[0] = 8'h3C; dv[0] = 1'b1; end
            if (k > 3 && m_acc[0]) dv[0] = 1'b0;
            if (done[0] && done_k < 0) done_k = k;
            if (done_k >= 0 && start2_k < 0 && sout[0] == 1'b0) start2_k = k;
        end
        check_eq("ign_first_frame", 32'(frame_at(0, 4)), 32'({1'b1, 8'hA5, 1'b0}));
        check_eq("ign_done_time", 32'(done_k), 32'd40);
        check_eq("ign_second_start", 32'(start2_k), 32'd41);
        check_eq("ign_second_frame", 32'(frame_at(41, 4)), 32'({1'b1, 8'h3C, 1'b0}));

        // Reset in cycle 17 of a frame, then a fresh 0x5A frame.
        din[0] = 8'hC3; dv[0] = 1'b1;
        step();
        dv[0] = 1'b0;
        for (int k = 1; k < 17; k++) step();
        async_reset(2);
        din[0] = 8'h5A; dv[0] = 1'b1;
        step();
        check_eq("rst_first_accept", 32'(busy[0]), 32'd1);
        dv[0] = 1'b0;
        sbuf[0] = sout[0];
        done_cnt = 0;
        for (int k = 1; k < 46; k++) begin
            step();
            sbuf[k] = sout[0];
            done_cnt += 32'(done[0]);
        end
        check_eq("rst_5a_frame", 32'(frame_at(0, 4)), 32'({1'b1, 8'h5A, 1'b0}));
        check_eq("rst_5a_done_count", 32'(done_cnt), 32'd1);

        // CLK_DIV=1 instance, 0x81.
        din[1] = 8'h81; dv[1] = 1'b1;
        step();
        dv[1] = 1'b0;
        sbuf[0] = sout[1];
        done_k = -1;
        for (int k = 1; k < 12; k++) begin
            step();
            if (k < 10) sbuf[k] = sout[1];
            if (done[1] && done_k < 0) done_k = k;
        end
        check_eq("div1_bits", 32'(frame_at(0, 1)), 32'(10'b1100000010));
        check_eq("div1_done_edge", 32'(done_k), 32'd10);

        // Randomized traffic on both instances with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            step();
            for (int u = 0; u < 2; u++) begin
                if (m_acc[u]) hold[u] = 1'b0;
                if (!hold[u]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        din[u] = 8'($urandom); dv[u] = 1'b1; hold[u] = 1'b1;
                    end else begin
                        din[u] = 8'($urandom); dv[u] = 1'b0;
                    end
                end
            end
            if ($urandom_range(0, 399) == 0) async_reset(1 + $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8, data bits per frame (legal range 1..32).
REQ-002 Parameter CLK_DIV, default 4, clock cycles per serial bit (legal range 1..65535).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 din  input  WIDTH  parallel word to transmit; sampled only on acceptance.
REQ-006 din_valid  input  1  producer asserts while din holds a word to send.
REQ-007 din_ready  output  1  block can accept a word this cycle.
REQ-008 sout  output  1  serial line, registered, idle-high.
REQ-009 busy  output  1  high while a frame is in progress.
REQ-010 done  output  1  one-cycle pulse on frame completion.

Function
REQ-011 The frame SHALL be, in order: 1 start bit (0), WIDTH data bits LSB first, 1 stop bit (1).
- Total frame length: (WIDTH+2)*CLK_DIV cycles.
REQ-012 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-013 Acceptance SHALL occur on a rising edge where din_valid=1 and din_ready=1.
- At acceptance: din is latched into the shift register; IDLE -> START.
REQ-014 din_ready SHALL be 1 only in IDLE.
- A word presented while busy=1 is neither latched nor lost; the producer holds it until ready.
REQ-015 sout SHALL change to the start bit (0) in the cycle after the acceptance edge (latency 1).
REQ-016 Each bit SHALL be held on sout for exactly CLK_DIV consecutive cycles, timed by a bit-cycle counter.
- The counter counts 0..CLK_DIV-1 and wraps to 0 at each bit boundary.
REQ-017 Transitions SHALL occur at the last cycle of a bit period:
- START -> DATA.
- DATA -> DATA until WIDTH bits are sent; the shift register shifts right 1 bit per bit period.
- DATA -> STOP after the last data bit.
- STOP -> IDLE.
REQ-018 The data-bit index counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL clear on entry to START.
REQ-019 done SHALL pulse high for exactly one cycle, on the cycle in which the state returns to IDLE.
- din_ready is high in that same cycle, so a back-to-back frame can be accepted there.
REQ-020 Back-to-back frames SHALL leave no idle bit between the stop bit and the next start bit beyond the one cycle of acceptance latency.
REQ-021 busy SHALL equal (state != IDLE).
REQ-022 In IDLE, sout SHALL be 1 and both counters SHALL hold at 0.
REQ-023 With CLK_DIV=1, every bit SHALL last one cycle and the behaviour in REQ-011..REQ-022 SHALL be unchanged.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force:
- state=IDLE, sout=1, busy=0, done=0, din_ready=1, all counters and the shift register to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame.
- No done pulse is generated.
- After rst deassertion, the next word is accepted as a fresh frame.
REQ-026 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-027 A shared package piso_pkg SHALL hold the four-state FSM typedef and the state encodings as named constants.
REQ-028 Bit timing SHALL be a sub-module bit_timer.
- Inputs: clk, rst, clear.
- Output: one-cycle tick on the last cycle of each bit period, parameter CLK_DIV.
REQ-029 piso_tx SHALL contain the FSM, the shift register, the bit-index counter and the output registers, with no other sub-modules.

Verification (WIDTH=8, CLK_DIV=4)
REQ-030 Single frame: din=0xA5, one-cycle din_valid. sout SHALL show 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high for 40 cycles; done pulses once.
REQ-031 Back-to-back: din_valid held high with 0x00 then 0xFF. The second start bit SHALL begin the cycle after done, and the two frames total 80 busy cycles.
REQ-032 Busy ignore: din changed to 0x3C while busy. Bits sent SHALL still be 0xA5; 0x3C is sent only after din_ready returns to 1.
REQ-033 Mid-frame reset: rst asserted in cycle 17 of a frame. sout=1 and busy=0 SHALL take effect asynchronously; no done pulse; the next frame 0x5A transmits correctly.
REQ-034 CLK_DIV=1 build, din=0x81: sout SHALL show 0,1,0,0,0,0,0,0,1,1 over 10 cycles, and done SHALL pulse in cycle 10.
